// File: rtl/des_decrypt_iter.sv
// Iterative DES decryption: one Feistel round per clock, reverse key schedule, valid/ready on both sides.
// Optional macro DES_KEY_PARITY_CHK_EN adds a registered key-parity error flag.
module des_sbox_lut #(
  parameter logic [255:0] TBL = '0
) (
  input  logic [5:0] a,
  output logic [3:0] o
);
  // Table is row-major, leftmost hex digit is entry 0; row = {b1,b6}, column = b2..b5.
  logic [5:0] idx;
  assign idx = {a[5], a[0], a[4:1]};
  assign o   = TBL[{~idx, 2'b00} +: 4];
endmodule

module sbox1 (input logic [5:0] a, output logic [3:0] o);
  des_sbox_lut #(.TBL(256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D)) u_lut (.a(a), .o(o));
endmodule
module sbox2 (input logic [5:0] a, output logic [3:0] o);
  des_sbox_lut #(.TBL(256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9)) u_lut (.a(a), .o(o));
endmodule
module sbox3 (input logic [5:0] a, output logic [3:0] o);
  des_sbox_lut #(.TBL(256'hA09E63F51DC7B428_D70934A6285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C)) u_lut (.a(a), .o(o));
endmodule
module sbox4 (input logic [5:0] a, output logic [3:0] o);
  des_sbox_lut #(.TBL(256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E)) u_lut (.a(a), .o(o));
endmodule
module sbox5 (input logic [5:0] a, output logic [3:0] o);
  des_sbox_lut #(.TBL(256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453)) u_lut (.a(a), .o(o));
endmodule
module sbox6 (input logic [5:0] a, output logic [3:0] o);
  des_sbox_lut #(.TBL(256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D)) u_lut (.a(a), .o(o));
endmodule
module sbox7 (input logic [5:0] a, output logic [3:0] o);
  des_sbox_lut #(.TBL(256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C)) u_lut (.a(a), .o(o));
endmodule
module sbox8 (input logic [5:0] a, output logic [3:0] o);
  des_sbox_lut #(.TBL(256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B)) u_lut (.a(a), .o(o));
endmodule

module des_decrypt_iter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] cipher_in,
  input  logic [63:0] key_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] plain_out,
`ifdef DES_KEY_PARITY_CHK_EN
  output logic        parity_err,
`endif
  output logic        busy
);
  // Tables use DES numbering: entry n selects input bit n, bit 1 being the MSB.
  localparam int IP_T [64] = '{58,50,42,34,26,18,10,2,60,52,44,36,28,20,12,4,62,54,46,38,30,22,14,6,
                               64,56,48,40,32,24,16,8,57,49,41,33,25,17,9,1,59,51,43,35,27,19,11,3,
                               61,53,45,37,29,21,13,5,63,55,47,39,31,23,15,7};
  localparam int FP_T [64] = '{40,8,48,16,56,24,64,32,39,7,47,15,55,23,63,31,38,6,46,14,54,22,62,30,
                               37,5,45,13,53,21,61,29,36,4,44,12,52,20,60,28,35,3,43,11,51,19,59,27,
                               34,2,42,10,50,18,58,26,33,1,41,9,49,17,57,25};
  localparam int E_T [48]  = '{32,1,2,3,4,5,4,5,6,7,8,9,8,9,10,11,12,13,12,13,14,15,16,17,
                               16,17,18,19,20,21,20,21,22,23,24,25,24,25,26,27,28,29,28,29,30,31,32,1};
  localparam int P_T [32]  = '{16,7,20,21,29,12,28,17,1,15,23,26,5,18,31,10,
                               2,8,24,14,32,27,3,9,19,13,30,6,22,11,4,25};
  localparam int PC1_T [56] = '{57,49,41,33,25,17,9,1,58,50,42,34,26,18,10,2,59,51,43,35,27,19,11,3,
                                60,52,44,36,63,55,47,39,31,23,15,7,62,54,46,38,30,22,14,6,
                                61,53,45,37,29,21,13,5,28,20,12,4};
  localparam int PC2_T [48] = '{14,17,11,24,1,5,3,28,15,6,21,10,23,19,12,4,26,8,16,7,27,20,13,2,
                                41,52,31,37,47,55,30,40,51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32};

  function automatic logic [63:0] f_ip(input logic [63:0] x);
    logic [63:0] y;
    for (int j = 0; j < 64; j++) y[6'(63 - j)] = x[6'(64 - IP_T[6'(j)])];
    return y;
  endfunction
  function automatic logic [63:0] f_fp(input logic [63:0] x);
    logic [63:0] y;
    for (int j = 0; j < 64; j++) y[6'(63 - j)] = x[6'(64 - FP_T[6'(j)])];
    return y;
  endfunction
  function automatic logic [47:0] f_e(input logic [31:0] x);
    logic [47:0] y;
    for (int j = 0; j < 48; j++) y[6'(47 - j)] = x[5'(32 - E_T[6'(j)])];
    return y;
  endfunction
  function automatic logic [31:0] f_p(input logic [31:0] x);
    logic [31:0] y;
    for (int j = 0; j < 32; j++) y[5'(31 - j)] = x[5'(32 - P_T[5'(j)])];
    return y;
  endfunction
  function automatic logic [55:0] f_pc1(input logic [63:0] x);
    logic [55:0] y;
    for (int j = 0; j < 56; j++) y[6'(55 - j)] = x[6'(64 - PC1_T[6'(j)])];
    return y;
  endfunction
  function automatic logic [47:0] f_pc2(input logic [55:0] x);
    logic [47:0] y;
    for (int j = 0; j < 48; j++) y[6'(47 - j)] = x[6'(56 - PC2_T[6'(j)])];
    return y;
  endfunction
  function automatic logic [27:0] rotr(input logic [27:0] x, input logic [1:0] n);
    case (n)
      2'd0:    return x;
      2'd1:    return {x[0], x[27:1]};
      default: return {x[1:0], x[27:2]};
    endcase
  endfunction

  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;
  state_t state, state_nxt;

  logic [31:0] l, r, r_new, f_out;
  logic [27:0] c, d, cn, dn;
  logic [3:0]  rnd;
  logic [1:0]  rot;
  logic [47:0] sbox_in;

  // Decrypt walks the encrypt shifts backwards: K16 needs no rotation, then right rotations.
  assign rot     = (rnd == 4'd0) ? 2'd0 :
                   (rnd == 4'd1 || rnd == 4'd8 || rnd == 4'd15) ? 2'd1 : 2'd2;
  assign cn      = rotr(c, rot);
  assign dn      = rotr(d, rot);
  assign sbox_in = f_e(r) ^ f_pc2({cn, dn});

  logic [3:0] s1, s2, s3, s4, s5, s6, s7, s8;
  sbox1 u_s1 (.a(sbox_in[47:42]), .o(s1));
  sbox2 u_s2 (.a(sbox_in[41:36]), .o(s2));
  sbox3 u_s3 (.a(sbox_in[35:30]), .o(s3));
  sbox4 u_s4 (.a(sbox_in[29:24]), .o(s4));
  sbox5 u_s5 (.a(sbox_in[23:18]), .o(s5));
  sbox6 u_s6 (.a(sbox_in[17:12]), .o(s6));
  sbox7 u_s7 (.a(sbox_in[11:6]),  .o(s7));
  sbox8 u_s8 (.a(sbox_in[5:0]),   .o(s8));

  assign f_out = f_p({s1, s2, s3, s4, s5, s6, s7, s8});
  assign r_new = l ^ f_out;

  assign in_ready = (state == IDLE);
  assign busy     = (state == ROUND);

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)         state_nxt = ROUND;
      ROUND:   if (rnd == 4'd15)     state_nxt = DONE;
      DONE:    if (out_ready)        state_nxt = IDLE;
      default:                       state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      l <= '0; r <= '0; c <= '0; d <= '0; rnd <= '0;
      plain_out <= '0; out_valid <= 1'b0;
`ifdef DES_KEY_PARITY_CHK_EN
      parity_err <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          {l, r} <= f_ip(cipher_in);
          {c, d} <= f_pc1(key_in);
          rnd    <= '0;
`ifdef DES_KEY_PARITY_CHK_EN
          parity_err <= ~^key_in[63:56] | ~^key_in[55:48] | ~^key_in[47:40] | ~^key_in[39:32] |
                        ~^key_in[31:24] | ~^key_in[23:16] | ~^key_in[15:8]  | ~^key_in[7:0];
`endif
        end
        ROUND: begin
          l <= r;
          r <= r_new;
          c <= cn;
          d <= dn;
          if (rnd != 4'd15) rnd <= rnd + 4'd1;
          else begin
            // Final swap is undone: preoutput is {R16, L16}.
            plain_out <= f_fp({r_new, r});
            out_valid <= 1'b1;
          end
        end
        DONE: if (out_ready) out_valid <= 1'b0;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_des_decrypt_iter.sv
// Directed-vector scoreboard bench for des_decrypt_iter.
module tb_des_decrypt_iter;
  logic        clk = 1'b0;
  logic        rst_n, in_valid, out_ready;
  logic        in_ready, out_valid, busy;
  logic [63:0] cipher_in, key_in, plain_out;
`ifdef DES_KEY_PARITY_CHK_EN
  logic        parity_err;
`endif

  des_decrypt_iter dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .cipher_in(cipher_in), .key_in(key_in), .out_valid(out_valid),
    .out_ready(out_ready), .plain_out(plain_out),
`ifdef DES_KEY_PARITY_CHK_EN
    .parity_err(parity_err),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  localparam logic [63:0] K1 = 64'h133457799BBCDFF1, C1 = 64'h85E813540F0AB405, P1 = 64'h0123456789ABCDEF;
  localparam logic [63:0] K2 = 64'h0E329232EA6D0D73, C2 = 64'h0000000000000000, P2 = 64'h8787878787878787;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, failures = 0;
  logic [63:0] sb[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Monitor: every completed output handshake is matched against the scoreboard.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_output actual=%h expected=none", plain_out);
      end else chk("plain_out", plain_out, sb.pop_front());
    end
  end

  // Leaves in_valid high on return; caller decides when to drop it.
  task automatic send(input logic [63:0] k, input logic [63:0] c, input logic [63:0] exp, output int acc);
    bit got = 0;
    @(posedge clk); #1;
    in_valid = 1'b1; key_in = k; cipher_in = c;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (in_ready) got = 1;
    end
    if (!got) chk("accept_timeout", 64'(in_ready), 64'd1);
    sb.push_back(exp);
    @(posedge clk); #1;
    acc = cyc;
    chk("busy_after_accept", 64'(busy), 64'd1);
    chk("in_ready_after_accept", 64'(in_ready), 64'd0);
  endtask

  task automatic wait_valid(input int acc);
    for (int i = 0; i < 40 && out_valid !== 1'b1; i++) @(negedge clk);
    chk("out_valid_seen", 64'(out_valid), 64'd1);
    chk("latency", 64'(cyc - acc), 64'd16);
    chk("busy_in_done", 64'(busy), 64'd0);
  endtask

  initial begin
    int a1, a2, bad;
    in_valid = 0; out_ready = 0; key_in = '0; cipher_in = '0;
    rst_n = 0;
    #2;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_plain_out", plain_out, 64'd0);
    @(posedge clk); #1 rst_n = 1;

    // Known answer
    out_ready = 1;
    send(K1, C1, P1, a1);
`ifdef DES_KEY_PARITY_CHK_EN
    chk("parity_good_key", 64'(parity_err), 64'd0);
`endif
    in_valid = 0;
    wait_valid(a1);
    @(posedge clk); #1;

    // Back-pressure hold
    out_ready = 0;
    send(K2, C2, P2, a1);
    in_valid = 0;
    wait_valid(a1);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (plain_out !== P2 || out_valid !== 1'b1 || in_ready !== 1'b0) bad++;
    end
    chk("backpressure_hold", 64'(bad), 64'd0);
    @(posedge clk); #1 out_ready = 1;
    @(posedge clk); #1;

    // Garbage on inputs while busy and done
    out_ready = 0;
    send(K1, C1, P1, a1);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      in_valid = 1'($urandom_range(0, 1));
      cipher_in = {$urandom, $urandom};
      key_in = {$urandom, $urandom};
      @(negedge clk);
      if (in_ready !== 1'b0) bad++;
    end
    chk("ignore_in_ready_low", 64'(bad), 64'd0);
    chk("ignore_out_valid", 64'(out_valid), 64'd1);
    in_valid = 0;
    @(posedge clk); #1 out_ready = 1;
    @(posedge clk); #1;
    chk("in_ready_after_consume", 64'(in_ready), 64'd1);

    // Reset during round 7
    send(K2, C2, P2, a1);
    in_valid = 0;
    repeat (7) @(posedge clk);
    #2;
    chk("busy_before_reset", 64'(busy), 64'd1);
    rst_n = 0;
    sb.delete();
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_plain_out", plain_out, 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    send(K1, C1, P1, a1);
    in_valid = 0;
    wait_valid(a1);
    @(posedge clk); #1;

    // Back-to-back with in_valid held high
    send(K2, C2, P2, a1);
    send(K1, C1, P1, a2);
    in_valid = 0;
    chk("b2b_spacing", 64'(a2 - a1), 64'd18);
    wait_valid(a2);
    @(posedge clk); #1;

`ifdef DES_KEY_PARITY_CHK_EN
    // Only the parity bit of the first byte differs from K1, so plaintext is unchanged.
    send(64'h123457799BBCDFF1, C1, P1, a1);
    in_valid = 0;
    chk("parity_bad_key", 64'(parity_err), 64'd1);
    wait_valid(a1);
    @(posedge clk); #1;
`endif

    repeat (3) @(posedge clk);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout actual=%0d cycles expected=completion", cyc);
    $fatal(1, "watchdog");
  end
endmodule
